// File: rtl/detector_trigger_responder.sv
// rtl/detector_trigger_responder.sv - detector-side trigger responder: sync, qualify, expose/readout FSM, counters
module detector_trigger_responder #(
    parameter int MIN_TRIGGER_CYCLES = 4,
    parameter int EXPOSURE_CYCLES    = 20_000,
    parameter int READOUT_CYCLES     = 1_280_000,
    parameter int CNT_W              = 32
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             enable_signal,
    input  logic             trigger_signal,
    output logic             detector_ready,
    output logic             exposure_active,
    output logic             frame_done,
    output logic [CNT_W-1:0] accepted_count,
    output logic [CNT_W-1:0] missed_count,
    output logic [7:0]       responder_state
);

    localparam int MAX_CYC = (EXPOSURE_CYCLES > READOUT_CYCLES) ? EXPOSURE_CYCLES : READOUT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
    localparam int HW      = $clog2(MIN_TRIGGER_CYCLES + 1);

    typedef enum logic [7:0] {
        S_DISABLED = 8'h00,
        S_IDLE     = 8'h01,
        S_EXPOSE   = 8'h02,
        S_READOUT  = 8'h04
    } state_t;

    state_t           state_q, state_d;
    logic             ff1_q, ff1_d, ff2_q, ff2_d;
    logic [1:0]       primed_q, primed_d;
    logic             armed_q, armed_d;
    logic [HW-1:0]    hi_cnt_q, hi_cnt_d;
    logic             qual_q, qual_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] acc_q, acc_d, miss_q, miss_d;

    // Synchroniser and pulse qualifier; primed_q marks when ff2 holds a genuine post-reset sample.
    always_comb begin
        ff1_d    = trigger_signal;
        ff2_d    = ff1_q;
        primed_d = {primed_q[0], 1'b1};
        armed_d  = armed_q | (primed_q[1] & ~ff2_q);
        hi_cnt_d = hi_cnt_q;
        qual_d   = 1'b0;
        if (!ff2_q) begin
            hi_cnt_d = '0;
        end else if (armed_q && hi_cnt_q != HW'(MIN_TRIGGER_CYCLES)) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
            qual_d   = (hi_cnt_q == HW'(MIN_TRIGGER_CYCLES - 1));
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        frame_done_d = 1'b0;
        acc_d        = acc_q;
        miss_d       = miss_q;
        case (state_q)
            S_DISABLED: begin
                if (enable_signal) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!enable_signal) begin
                    state_d = S_DISABLED;
                end else if (qual_q) begin
                    state_d = S_EXPOSE;
                    timer_d = TW'(EXPOSURE_CYCLES - 1);
                    if (acc_q != '1) acc_d = acc_q + 1'b1;
                end
            end
            S_EXPOSE: begin
                if (timer_q == '0) begin
                    state_d = S_READOUT;
                    timer_d = TW'(READOUT_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_READOUT: begin
                if (timer_q == '0) begin
                    state_d      = enable_signal ? S_IDLE : S_DISABLED;
                    frame_done_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_DISABLED;
        endcase
        if (qual_q && (state_q == S_EXPOSE || state_q == S_READOUT) && miss_q != '1)
            miss_d = miss_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q      <= S_DISABLED;
            ff1_q        <= 1'b0;
            ff2_q        <= 1'b0;
            primed_q     <= 2'b00;
            armed_q      <= 1'b0;
            hi_cnt_q     <= '0;
            qual_q       <= 1'b0;
            timer_q      <= '0;
            frame_done_q <= 1'b0;
            acc_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            ff1_q        <= ff1_d;
            ff2_q        <= ff2_d;
            primed_q     <= primed_d;
            armed_q      <= armed_d;
            hi_cnt_q     <= hi_cnt_d;
            qual_q       <= qual_d;
            timer_q      <= timer_d;
            frame_done_q <= frame_done_d;
            acc_q        <= acc_d;
            miss_q       <= miss_d;
        end
    end

    assign detector_ready  = (state_q == S_IDLE);
    assign exposure_active = (state_q == S_EXPOSE);
    assign responder_state = state_q;
    assign frame_done      = frame_done_q;
    assign accepted_count  = acc_q;
    assign missed_count    = miss_q;

endmodule

// File: tb/tb_detector_trigger_responder.sv
// tb/tb_detector_trigger_responder.sv - directed self-checking bench for detector_trigger_responder
module tb_detector_trigger_responder;

    logic       clock = 1'b0;
    logic       reset_signal, enable_signal, trigger_signal;
    logic       detector_ready, exposure_active, frame_done;
    logic [3:0] accepted_count, missed_count;
    logic [7:0] responder_state;
    int         checks = 0;
    int         errors = 0;
    int         pulses;

    always #5 clock = ~clock;

    detector_trigger_responder #(
        .MIN_TRIGGER_CYCLES(4),
        .EXPOSURE_CYCLES(10),
        .READOUT_CYCLES(50),
        .CNT_W(4)
    ) dut (
        .clock          (clock),
        .reset_signal   (reset_signal),
        .enable_signal  (enable_signal),
        .trigger_signal (trigger_signal),
        .detector_ready (detector_ready),
        .exposure_active(exposure_active),
        .frame_done     (frame_done),
        .accepted_count (accepted_count),
        .missed_count   (missed_count),
        .responder_state(responder_state)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_signal = 1'b1; enable_signal = 1'b0; trigger_signal = 1'b0;
        tick(3);
        chk("rst_state", 32'(responder_state), 32'h00);
        chk("rst_ready", 32'(detector_ready), 32'd0);
        chk("rst_acc", 32'(accepted_count), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        reset_signal = 1'b0; enable_signal = 1'b1;
        tick(5);
        chk("en_idle", 32'(responder_state), 32'h01);

        // 1: basic frame timing
        trigger_signal = 1'b1;
        tick(6);
        chk("t1_pre", 32'(responder_state), 32'h01);
        tick(1);
        chk("t1_expose", 32'(responder_state), 32'h02);
        chk("t1_expact", 32'(exposure_active), 32'd1);
        chk("t1_acc", 32'(accepted_count), 32'd1);
        tick(3);
        trigger_signal = 1'b0;
        tick(6);
        chk("t1_exp_end", 32'(responder_state), 32'h02);
        tick(1);
        chk("t1_readout", 32'(responder_state), 32'h04);
        tick(49);
        chk("t1_ro_end", 32'(responder_state), 32'h04);
        chk("t1_fd_pre", 32'(frame_done), 32'd0);
        tick(1);
        chk("t1_idle", 32'(responder_state), 32'h01);
        chk("t1_fd", 32'(frame_done), 32'd1);
        chk("t1_ready", 32'(detector_ready), 32'd1);
        chk("t1_miss", 32'(missed_count), 32'd0);
        tick(1);
        chk("t1_fd_post", 32'(frame_done), 32'd0);

        // 2: 3-cycle pulse dropped, 4-cycle pulse qualifies
        trigger_signal = 1'b1; tick(3); trigger_signal = 1'b0;
        tick(10);
        chk("t2_short_state", 32'(responder_state), 32'h01);
        chk("t2_short_acc", 32'(accepted_count), 32'd1);
        chk("t2_short_miss", 32'(missed_count), 32'd0);
        trigger_signal = 1'b1; tick(4); trigger_signal = 1'b0;
        tick(2);
        chk("t2_min_pre", 32'(responder_state), 32'h01);
        tick(1);
        chk("t2_min_exp", 32'(responder_state), 32'h02);
        chk("t2_min_acc", 32'(accepted_count), 32'd2);

        // 3: trigger 20 cycles into readout is missed, frame timing unchanged
        tick(29);
        trigger_signal = 1'b1; tick(10); trigger_signal = 1'b0;
        chk("t3_state", 32'(responder_state), 32'h04);
        chk("t3_miss", 32'(missed_count), 32'd1);
        tick(20);
        chk("t3_ro_end", 32'(responder_state), 32'h04);
        tick(1);
        chk("t3_idle", 32'(responder_state), 32'h01);
        chk("t3_fd", 32'(frame_done), 32'd1);
        chk("t3_acc", 32'(accepted_count), 32'd2);

        // 4: held-high trigger yields exactly one frame
        trigger_signal = 1'b1;
        tick(7);
        chk("t4_exp", 32'(responder_state), 32'h02);
        tick(193);
        chk("t4_state", 32'(responder_state), 32'h01);
        chk("t4_acc", 32'(accepted_count), 32'd3);
        chk("t4_miss", 32'(missed_count), 32'd1);
        trigger_signal = 1'b0; tick(5);

        // 5: enable dropped during exposure; frame completes then disabled
        trigger_signal = 1'b1;
        tick(7);
        chk("t5_exp", 32'(responder_state), 32'h02);
        trigger_signal = 1'b0; enable_signal = 1'b0;
        tick(59);
        chk("t5_ro", 32'(responder_state), 32'h04);
        tick(1);
        chk("t5_dis", 32'(responder_state), 32'h00);
        chk("t5_ready", 32'(detector_ready), 32'd0);
        chk("t5_fd", 32'(frame_done), 32'd1);
        trigger_signal = 1'b1; tick(10); trigger_signal = 1'b0; tick(5);
        chk("t5_dis_trig", 32'(responder_state), 32'h00);
        chk("t5_dis_acc", 32'(accepted_count), 32'd4);
        chk("t5_dis_miss", 32'(missed_count), 32'd1);
        enable_signal = 1'b1; tick(1);
        chk("t5_reen", 32'(responder_state), 32'h01);

        // 6: reset mid-readout with trigger held high, then counter saturation
        trigger_signal = 1'b1;
        tick(7);
        chk("t6_exp", 32'(accepted_count), 32'd5);
        tick(30);
        chk("t6_ro", 32'(responder_state), 32'h04);
        reset_signal = 1'b1; tick(1); reset_signal = 1'b0;
        chk("t6_rst_state", 32'(responder_state), 32'h00);
        chk("t6_rst_acc", 32'(accepted_count), 32'd0);
        chk("t6_rst_miss", 32'(missed_count), 32'd0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (frame_done) pulses++;
        end
        chk("t6_no_fd", 32'(pulses), 32'd0);
        chk("t6_held_idle", 32'(responder_state), 32'h01);
        chk("t6_held_acc", 32'(accepted_count), 32'd0);
        trigger_signal = 1'b0; tick(3);
        trigger_signal = 1'b1; tick(7);
        chk("t6_rearm", 32'(responder_state), 32'h02);
        chk("t6_rearm_acc", 32'(accepted_count), 32'd1);
        tick(3); trigger_signal = 1'b0; tick(62);
        for (int i = 0; i < 19; i++) begin
            trigger_signal = 1'b1; tick(10);
            trigger_signal = 1'b0; tick(60);
        end
        chk("t6_sat_state", 32'(responder_state), 32'h01);
        chk("t6_sat_acc", 32'(accepted_count), 32'hF);
        chk("t6_sat_miss", 32'(missed_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
